// File: rtl/sobol_pkg.sv
// rtl/sobol_pkg.sv - shared width default and direction-vector helpers for the Sobol dimension-1 RNG
//
// Contents:
//   SOBOL_WIDTH  default output/counter width (mirrors the codebase-wide INWD)
//   SOBOL_MAXW   widest WIDTH the helper functions accept
//   lsz_idx      index of the least-significant zero bit of a w-bit value; all-ones maps to w-1
//   sobol_dir    dimension-1 direction vector v[k] = 1 << (w-1-k) for a w-bit sequence
package sobol_pkg;

    localparam int SOBOL_WIDTH = 8;
    localparam int SOBOL_MAXW  = 32;

    // Scanning from the top down leaves the lowest zero position in r.
    // When no zero exists below bit w, r keeps its initial w-1, which makes
    // the final step of a period clear the last remaining bit of the output.
    function automatic int lsz_idx(input logic [SOBOL_MAXW-1:0] v, input int w);
        int r;
        r = w - 1;
        for (int i = SOBOL_MAXW - 1; i >= 0; i--) begin
            if (i < w && !v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    // Van der Corput base 2: direction vectors are single bits placed MSB-first.
    function automatic logic [SOBOL_MAXW-1:0] sobol_dir(input int k, input int w);
        return SOBOL_MAXW'(1) << (w - 1 - k);
    endfunction

endpackage

// File: rtl/sobol_lsz_detect.sv
// rtl/sobol_lsz_detect.sv - least-significant-zero priority encoder for the Sobol counter
//
// Ports:
//   cnt  in   WIDTH  sequence counter
//   c    out  CW     index of the lowest zero bit of cnt; WIDTH-1 when cnt is all ones
module sobol_lsz_detect
    import sobol_pkg::*;
#(
    parameter int WIDTH = SOBOL_WIDTH,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] cnt,
    output logic [CW-1:0]    c
);

    assign c = CW'(lsz_idx(SOBOL_MAXW'(cnt), WIDTH));

endmodule

// File: rtl/sobol_rng_dim1.sv
// rtl/sobol_rng_dim1.sv - Sobol dimension-1 (van der Corput base 2) quasi-random number source
//
// Emits one WIDTH-bit value per enabled clock using the Gray-code recurrence
// sobolSeq ^= v[lsz(cnt)], so sobolSeq always equals bitreverse(gray(cnt)).
// Sequence period is 2**WIDTH; the first value after reset is 0.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   enable    in   1      advance the sequence on this edge
//   sobolSeq  out  WIDTH  current Sobol number (registered)
//   idx       out  WIDTH  current sequence index, present only with SOBOL_RNG_IDX_EN
//
// Build option: SOBOL_RNG_IDX_EN exposes the internal counter as idx.
module sobol_rng_dim1
    import sobol_pkg::*;
#(
    parameter int WIDTH = SOBOL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] sobolSeq
`ifdef SOBOL_RNG_IDX_EN
    ,
    output logic [WIDTH-1:0] idx
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] cnt;
    logic [CW-1:0]    c;
    logic [WIDTH-1:0] dir;

    sobol_lsz_detect #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_lsz (
        .cnt (cnt),
        .c   (c)
    );

    // Direction vectors are constants; only the selected bit position varies.
    assign dir = WIDTH'(sobol_dir(int'(c), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sobolSeq <= '0;
        end else if (enable) begin
            sobolSeq <= sobolSeq ^ dir;
            cnt      <= cnt + WIDTH'(1);
        end
    end

`ifdef SOBOL_RNG_IDX_EN
    // cnt is already a register, so idx shares sobolSeq's timing exactly.
    assign idx = cnt;
`else
    // cnt stays internal; it is fully consumed by the priority encoder.
`endif

endmodule

// File: tb/tb_sobol_rng_dim1.sv
// tb/tb_sobol_rng_dim1.sv - directed self-checking bench for sobol_rng_dim1 (WIDTH=8)
module tb_sobol_rng_dim1;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] sobolSeq;
`ifdef SOBOL_RNG_IDX_EN
    logic [W-1:0] idx;
`endif

    int n_checks;
    int n_fail;
    int n;

    logic [7:0] free_tbl [16];
    bit         seen [256];

    sobol_rng_dim1 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sobolSeq (sobolSeq)
`ifdef SOBOL_RNG_IDX_EN
        ,
        .idx      (idx)
`endif
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent closed form: bitreverse(gray(k)).
    function automatic logic [7:0] model(input int k);
        logic [7:0] g;
        logic [7:0] r;
        g = 8'(k) ^ (8'(k) >> 1);
        for (int i = 0; i < 8; i++) r[i] = g[7-i];
        return r;
    endfunction

    task automatic check_now(input string tag);
        chk(tag, 32'(sobolSeq), 32'(model(n)));
`ifdef SOBOL_RNG_IDX_EN
        chk({tag, "_idx"}, 32'(idx), 32'(n % 256));
`endif
    endtask

    // Inputs change and outputs are sampled only at falling edges.
    task automatic step(input logic en);
        enable = en;
        @(negedge clk);
        if (en) n++;
    endtask

    task automatic reset_between_edges();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        enable = 1'b1;
        #1;
        chk("async_rst", 32'(sobolSeq), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'(sobolSeq), 32'd0);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        free_tbl = '{8'd0, 8'd128, 8'd192, 8'd64, 8'd96, 8'd224, 8'd160, 8'd32,
                     8'd48, 8'd176, 8'd240, 8'd112, 8'd80, 8'd208, 8'd144, 8'd16};
        n_checks = 0;
        n_fail   = 0;
        n        = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;

        // Reset held 15 ns with enable high; release on a falling edge.
        @(negedge clk);
        chk("reset_a", 32'(sobolSeq), 32'd0);
        @(negedge clk);
        chk("reset_b", 32'(sobolSeq), 32'd0);
        rst_n = 1'b1;
        check_now("post_reset");

        // Free run against the hand-written table.
        for (int i = 1; i < 16; i++) begin
            step(1'b1);
            chk($sformatf("free_run_%0d", i), 32'(sobolSeq), 32'(free_tbl[i]));
        end

        // Hold at 192 for five cycles, then resume.
        reset_between_edges();
        step(1'b1);
        step(1'b1);
        chk("hold_pre", 32'(sobolSeq), 32'd192);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk($sformatf("hold_%0d", i), 32'(sobolSeq), 32'd192);
        end
        step(1'b1);
        chk("hold_resume", 32'(sobolSeq), 32'd64);

        // Full period: every value once, 1 at step 255, 0 at step 256.
        reset_between_edges();
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[sobolSeq] = 1'b1;
        for (int s = 1; s <= 256; s++) begin
            step(1'b1);
            if (s < 256) seen[sobolSeq] = 1'b1;
            if (s % 32 == 0) check_now($sformatf("period_%0d", s));
            if (s == 255) chk("last_before_wrap", 32'(sobolSeq), 32'd1);
            if (s == 256) chk("wrap_zero", 32'(sobolSeq), 32'd0);
        end
        begin
            int cnt_seen;
            cnt_seen = 0;
            for (int i = 0; i < 256; i++) if (seen[i]) cnt_seen++;
            chk("distinct_values", 32'(cnt_seen), 32'd256);
        end

        // Continue after wrap to 224, then async reset between edges.
        n = 0;
        for (int i = 0; i < 5; i++) step(1'b1);
        chk("pre_midreset", 32'(sobolSeq), 32'd224);
        reset_between_edges();
        step(1'b1);
        chk("restart_1", 32'(sobolSeq), 32'd128);
        step(1'b1);
        chk("restart_2", 32'(sobolSeq), 32'd192);
        check_now("restart_model");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
